// File: rtl/mode_ctrl_if.sv
// Button, player-handshake and display signals of the piano mode sequencer.
// The master side drives buttons and song_done; the slave side is mode_ctrl.
interface mode_ctrl_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_confirm;
   logic       btn_back;
   logic       song_done;
   logic [2:0] state;
   logic [2:0] cursor;
   logic [1:0] song;
   logic       running;
   logic       play_start;
   logic       play_abort;
   logic [1:0] tempo;

   modport master (
      output btn_up, btn_down, btn_confirm, btn_back, song_done,
      input  state, cursor, song, running, play_start, play_abort, tempo
   );

   modport slave (
      input  btn_up, btn_down, btn_confirm, btn_back, song_done,
      output state, cursor, song, running, play_start, play_abort, tempo
   );
endinterface

// File: rtl/mode_ctrl.sv
// Piano mode sequencer: debounces four buttons and runs the menu/song/tempo FSM.
// Optional idle return-to-menu is built when MODE_CTRL_IDLE_TIMEOUT_EN is defined.
module mode_ctrl #(
   parameter int DEBOUNCE_CYCLES = 2000000,
   parameter int NUM_SONGS       = 2
`ifdef MODE_CTRL_IDLE_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES  = 1000000000
`endif
) (
   input logic        clk,
   input logic        rst_n,
   mode_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      MENU = 3'd0,
      FREE = 3'd1,
      AUTO = 3'd2,
      STDY = 3'd3,
      PLAY = 3'd4,
      SET  = 3'd5
   } mode_e;

   localparam int             CntW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]     SongLast = 2'(NUM_SONGS - 1);

   // Bit order everywhere in the input path: [0]=up [1]=down [2]=confirm [3]=back.
   logic [3:0]            raw;
   logic [3:0]            sync1_q;
   logic [3:0]            sync2_q;
   logic [3:0][CntW-1:0]  cnt_q;
   logic [3:0]            deb_q;
   logic [3:0]            debPrev_q;
   logic [3:0]            press_q;

   logic upEv;
   logic downEv;
   logic confirmEv;
   logic backEv;
   logic effRunning;

   mode_e      state_q, state_d;
   logic [2:0] cursor_q, cursor_d;
   logic [1:0] song_q, song_d;
   logic       running_q, running_d;
   logic       playStart_q, playStart_d;
   logic       playAbort_q, playAbort_d;
   logic [1:0] tempo_q, tempo_d;

   assign raw = {bus.btn_back, bus.btn_confirm, bus.btn_down, bus.btn_up};

   // Synchronise, debounce and edge-detect each button; a level is accepted only
   // after it has differed from the debounced level for DEBOUNCE_CYCLES cycles in a row.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cnt_q     <= '0;
         deb_q     <= '0;
         debPrev_q <= '0;
         press_q   <= '0;
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         debPrev_q <= deb_q;
         press_q   <= deb_q & ~debPrev_q;
         for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CntLast) begin
               cnt_q[i] <= '0;
               deb_q[i] <= sync2_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign backEv    = press_q[3];
   assign confirmEv = press_q[2] & ~press_q[3];
   assign upEv      = press_q[0] & ~press_q[2] & ~press_q[3];
   assign downEv    = press_q[1] & ~press_q[0] & ~press_q[2] & ~press_q[3];

`ifdef MODE_CTRL_IDLE_TIMEOUT_EN
   localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] idleCnt_q, idleCnt_d;
   logic        anyEv;
   assign anyEv = |press_q;
`endif

   // Mode FSM: a finishing song counts as already stopped, so a back arriving
   // in the same cycle is handled as the idle back and leaves the mode.
   always_comb begin
      state_d     = state_q;
      cursor_d    = cursor_q;
      song_d      = song_q;
      running_d   = running_q;
      tempo_d     = tempo_q;
      playStart_d = 1'b0;
      playAbort_d = 1'b0;
      effRunning  = running_q & ~bus.song_done;

      if (running_q && bus.song_done) begin
         running_d = 1'b0;
      end

      case (state_q)
         MENU: begin
            if (backEv) begin
               state_d = MENU;
            end else if (confirmEv) begin
               state_d = mode_e'(cursor_q);
            end else if (upEv) begin
               cursor_d = (cursor_q == 3'd5) ? 3'd1 : cursor_q + 3'd1;
            end else if (downEv) begin
               cursor_d = (cursor_q == 3'd1) ? 3'd5 : cursor_q - 3'd1;
            end
         end
         FREE, SET: begin
            if (backEv) begin
               state_d = MENU;
            end else if (state_q == SET) begin
               if (upEv && tempo_q != 2'd3) begin
                  tempo_d = tempo_q + 2'd1;
               end else if (downEv && tempo_q != 2'd0) begin
                  tempo_d = tempo_q - 2'd1;
               end
            end
         end
         AUTO, STDY, PLAY: begin
            if (effRunning) begin
               if (backEv) begin
                  playAbort_d = 1'b1;
                  running_d   = 1'b0;
               end
            end else if (backEv) begin
               state_d = MENU;
            end else if (confirmEv) begin
               playStart_d = 1'b1;
               running_d   = 1'b1;
            end else if (upEv) begin
               song_d = (song_q == SongLast) ? 2'd0 : song_q + 2'd1;
            end else if (downEv) begin
               song_d = (song_q == 2'd0) ? SongLast : song_q - 2'd1;
            end
         end
         default: begin
            state_d = MENU;
         end
      endcase

`ifdef MODE_CTRL_IDLE_TIMEOUT_EN
      if (idleCnt_q == TimeoutLast && !anyEv && !running_q && state_q != MENU) begin
         state_d  = MENU;
         cursor_d = state_q;
      end
`endif
   end

`ifdef MODE_CTRL_IDLE_TIMEOUT_EN
   // Idle counter only runs while a mode is open and nothing is playing.
   always_comb begin
      idleCnt_d = idleCnt_q + 32'd1;
      if (anyEv || state_d != state_q || running_q || state_q == MENU) begin
         idleCnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idleCnt_q <= '0;
      end else begin
         idleCnt_q <= idleCnt_d;
      end
   end
`endif

   // All visible outputs are registered so the display and player see clean levels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= MENU;
         cursor_q    <= 3'd1;
         song_q      <= 2'd0;
         running_q   <= 1'b0;
         playStart_q <= 1'b0;
         playAbort_q <= 1'b0;
         tempo_q     <= 2'd1;
      end else begin
         state_q     <= state_d;
         cursor_q    <= cursor_d;
         song_q      <= song_d;
         running_q   <= running_d;
         playStart_q <= playStart_d;
         playAbort_q <= playAbort_d;
         tempo_q     <= tempo_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.cursor     = cursor_q;
   assign bus.song       = song_q;
   assign bus.running    = running_q;
   assign bus.play_start = playStart_q;
   assign bus.play_abort = playAbort_q;
   assign bus.tempo      = tempo_q;

endmodule

// File: doc/mode_ctrl.md
Name: mode_ctrl

Overview:
- Top-level mode sequencer for the piano.
- Turns four raw push-buttons into the `state` and `song` codes that drive the seven-segment menu display, the note player and the study/scoring logic.
- Owns the menu cursor, per-mode song selection, play start/abort handshakes with the song player, and the tempo setting edited in set mode.

Parameters:
- DEBOUNCE_CYCLES, 2000000, consecutive stable cycles before a button level is accepted (20 ms at 100 MHz).
- NUM_SONGS, 2, number of selectable songs; song index wraps modulo this value.
- TIMEOUT_CYCLES, 1000000000, idle cycles before automatic return to menu (10 s; used only with the optional feature).

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- btn_up, input, 1: raw button, asynchronous to clk.
- btn_down, input, 1: raw button, asynchronous to clk.
- btn_confirm, input, 1: raw button, asynchronous to clk.
- btn_back, input, 1: raw button, asynchronous to clk.
- song_done, input, 1: one-cycle pulse from the player when a song finishes.
- state, output, STATE_BITS (3): current mode. menu_mode=0, free_mode=1, auto_mode=2, stdy_mode=3, play_mode=4, set=5.
- cursor, output, STATE_BITS: mode highlighted in menu, range 1..5.
- song, output, SONG_BITS (2): selected song index. little_star=0, two_tigers=1.
- running, output, 1: player active.
- play_start, output, 1: one-cycle pulse that starts the player.
- play_abort, output, 1: one-cycle pulse that stops the player.
- tempo, output, 2: tempo level 0..3.

Behaviour:
- Reset (async, rst_n low): state=0, cursor=1, song=0, running=0, play_start=0, play_abort=0, tempo=1. All debounce counters and synchronizers clear.
- Input path, per button:
  - 2-flop synchronizer.
  - Counter restarts on any change of the synchronized level. The debounced level updates when the level has been stable DEBOUNCE_CYCLES cycles.
  - A press event is a registered rising edge of the debounced level. Releases generate no event.
- Latency: the registered output change appears exactly DEBOUNCE_CYCLES+4 clk cycles after the raw rising edge.
- Simultaneous events in one cycle: only one is acted on. Priority back > confirm > up > down; lower-priority events that cycle are dropped.
- MENU (state=0):
  - up: cursor+1, wrapping 5→1.
  - down: cursor−1, wrapping 1→5.
  - confirm: state←cursor.
  - back: ignored.
- FREE (1) and SET (5):
  - back: state←0, cursor unchanged.
  - In SET only: up does tempo+1, down does tempo−1, both saturating at 0 and 3.
  - confirm: ignored.
- AUTO / STDY / PLAY (2/3/4), running=0:
  - up: song+1 mod NUM_SONGS.
  - down: song−1 mod NUM_SONGS.
  - confirm: play_start=1 for one cycle, running←1.
  - back: state←0.
- AUTO / STDY / PLAY, running=1:
  - up, down and confirm are ignored; song is frozen.
  - back: play_abort=1 for one cycle, running←0, state unchanged. A second back returns to menu.
- song_done while running=1: running←0, no pulse. song_done while running=0 is ignored.
- song_done and a back event in the same cycle: song_done wins, running←0, no play_abort. The back event is consumed as the "running=0" back, so state←0.
- play_start and play_abort are never high in the same cycle. Each is high for exactly one cycle.
- song is retained across mode changes; tempo is retained until reset.
- Reset asserted mid-play forces running=0 immediately, with no play_abort pulse.

Optional Feature:
- Macro: MODE_CTRL_IDLE_TIMEOUT_EN.
- Defined:
  - A 32-bit idle counter increments every cycle while running=0 and state≠0.
  - It clears on any accepted button event, on any state change, and while running=1.
  - On reaching TIMEOUT_CYCLES: state←0, cursor←previous state, counter clears. No pulses are generated.
- Undefined: no counter is built, and modes persist indefinitely.

Test Plan (DEBOUNCE_CYCLES=4, NUM_SONGS=2, TIMEOUT_CYCLES=50):
- Reset, then down press → cursor=5 at cycle 8 after the raw edge. Confirm → state=5.
- In SET with tempo=1: up ×3 → tempo 2, 3, 3. Down ×4 → tempo ends at 0. Back → state=0, cursor=5.
- A 2-cycle glitch on btn_up → no event, cursor unchanged. A 6-cycle pulse → exactly one event.
- Menu cursor=2, confirm → state=2. Up → song=1, then up → song=0. Confirm → one-cycle play_start, running=1. Up → song stays 0. Back → play_abort pulse, running=0, state=2. Back → state=0.
- In PLAY running=1, song_done and back in the same cycle → running=0, no play_abort, state=0. Up and confirm raw presses aligned so their events coincide → only confirm acted on.
- With MODE_CTRL_IDLE_TIMEOUT_EN, in FREE idle for 50 cycles → state=0, cursor=1. Without the macro → state stays 1 after 200 cycles.
